pc_counter: RTL and testbench

Clocked program counter: a 16-bit register that on each rising clock edge either clears, loads a new value, increments, or holds. It is the first sequential stage downstream of the basic gate cells. Its increment path is built from those gate cells and its registered output feeds instruction-address consumers. It also flags wrap-around so later stages can detect address overflow.

---
 rtl/pc_counter_pkg.sv | 12 +
 rtl/pc_counter_inc_n.sv | 29 ++
 rtl/pc_counter.sv | 64 ++++++
 tb/tb_pc_counter.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/pc_counter_pkg.sv
// Shared definitions for the program counter: default width and
// control-state encoding exposed for debug visibility.
package pc_counter_pkg;

    localparam int unsigned PC_WIDTH = 16;

    localparam logic [1:0] ST_RESET = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_INC   = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

endpackage

// File: rtl/pc_counter_inc_n.sv
// Ripple incrementer built from nand-only half-adder cells; the carry
// into bit 0 is tied high, so carry_out flags an all-ones input.
module inc_n #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    logic [WIDTH:0] c;

    assign c[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ha
        logic n1;
        logic n2;
        logic n3;
        // and = nand(nand), xor = classic four-nand network
        assign n1     = ~(a[i] & c[i]);
        assign c[i+1] = ~(n1 & n1);
        assign n2     = ~(a[i] & n1);
        assign n3     = ~(c[i] & n1);
        assign sum[i] = ~(n2 & n3);
    end

    assign carry_out = c[WIDTH];

endmodule

// File: rtl/pc_counter.sv
// Program counter: clear / load / increment / hold with a registered
// one-cycle wrap pulse on increment from all-ones.
module pc_counter
    import pc_counter_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             inc,
    output logic [WIDTH-1:0] out,
    output logic             wrap
);

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] inc_sum;
    logic             inc_carry;
    logic             wrap_q;
    logic             wrap_d;
    logic [1:0]       state;

    inc_n #(.WIDTH(WIDTH)) u_inc (
        .a         (out_q),
        .sum       (inc_sum),
        .carry_out (inc_carry)
    );

    // Several controls may be high at once; earlier arms win.
    always_comb begin
        state = ST_HOLD;
        priority case (1'b1)
            reset:   state = ST_RESET;
            load:    state = ST_LOAD;
            inc:     state = ST_INC;
            default: state = ST_HOLD;
        endcase
    end

    always_comb begin
        out_d  = out_q;
        wrap_d = 1'b0;
        case (state)
            ST_RESET: out_d = '0;
            ST_LOAD:  out_d = in;
            ST_INC: begin
                out_d  = inc_sum;
                wrap_d = inc_carry;
            end
            default:  out_d = out_q;
        endcase
    end

    always_ff @(posedge clk) begin
        out_q  <= out_d;
        wrap_q <= wrap_d;
    end

    assign out  = out_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_pc_counter.sv
// Self-checking bench for pc_counter: directed vector table, hand-written
// corner sequences, then random traffic against an arithmetic model.
module tb_pc_counter;

    logic        clk;
    logic        reset;
    logic [15:0] in;
    logic        load;
    logic        inc;
    logic [15:0] out;
    logic        wrap;

    int n_total = 0;
    int n_pass  = 0;

    int unsigned m_out  = 0;
    bit          m_wrap = 0;

    typedef struct {
        logic        r;
        logic        l;
        logic        i;
        logic [15:0] d;
        logic [15:0] eo;
        logic        ew;
    } vec_t;

    vec_t vecs[$];

    pc_counter #(.WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .in    (in),
        .load  (load),
        .inc   (inc),
        .out   (out),
        .wrap  (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(logic r, logic l, logic i, logic [15:0] d,
                                logic [15:0] eo, logic ew);
        vec_t v;
        v.r = r; v.l = l; v.i = i; v.d = d; v.eo = eo; v.ew = ew;
        vecs.push_back(v);
    endfunction

    // Reference behaviour straight from the priority rules.
    function automatic void model_step(logic r, logic l, logic i,
                                       logic [15:0] d);
        if (r) begin
            m_out = 0; m_wrap = 0;
        end else if (l) begin
            m_out = d; m_wrap = 0;
        end else if (i) begin
            m_wrap = (m_out == 16'hFFFF);
            m_out  = (m_out + 1) % 65536;
        end else begin
            m_wrap = 0;
        end
    endfunction

    task automatic chk(string nm, logic [15:0] act_o, logic act_w,
                       logic [15:0] exp_o, logic exp_w);
        n_total++;
        if (act_o === exp_o && act_w === exp_w) n_pass++;
        else $display("FAIL %s: out=%h wrap=%b, expected out=%h wrap=%b",
                      nm, act_o, act_w, exp_o, exp_w);
    endtask

    task automatic step(logic r, logic l, logic i, logic [15:0] d);
        reset = r; load = l; inc = i; in = d;
        model_step(r, l, i, d);
        @(posedge clk);
        #1;
    endtask

    task automatic dstep(string nm, logic r, logic l, logic i,
                         logic [15:0] d, logic [15:0] eo, logic ew);
        step(r, l, i, d);
        chk(nm, out, wrap, eo, ew);
    endtask

    initial begin
        reset = 1'b0; load = 1'b0; inc = 1'b0; in = '0;
        @(posedge clk);
        #1;

        // reset wins over load and inc
        add(1, 1, 1, 16'h1234, 16'h0000, 0);
        add(1, 1, 1, 16'h1234, 16'h0000, 0);
        // count 1..5, then hold
        add(0, 0, 1, 16'h0000, 16'h0001, 0);
        add(0, 0, 1, 16'h0000, 16'h0002, 0);
        add(0, 0, 1, 16'h0000, 16'h0003, 0);
        add(0, 0, 1, 16'h0000, 16'h0004, 0);
        add(0, 0, 1, 16'h0000, 16'h0005, 0);
        add(0, 0, 0, 16'h7777, 16'h0005, 0);
        add(0, 0, 0, 16'h7777, 16'h0005, 0);
        add(0, 0, 0, 16'h7777, 16'h0005, 0);
        // load beats inc
        add(0, 1, 1, 16'hABCD, 16'hABCD, 0);
        add(0, 0, 1, 16'h0000, 16'hABCE, 0);
        // wrap through all-ones
        add(0, 1, 0, 16'hFFFE, 16'hFFFE, 0);
        add(0, 0, 1, 16'h0000, 16'hFFFF, 0);
        add(0, 0, 1, 16'h0000, 16'h0000, 1);
        add(0, 0, 1, 16'h0000, 16'h0001, 0);
        // loading all-ones never wraps; following inc does
        add(0, 1, 0, 16'hFFFF, 16'hFFFF, 0);
        add(0, 0, 1, 16'h0000, 16'h0000, 1);
        add(0, 0, 0, 16'h0000, 16'h0000, 0);

        foreach (vecs[k]) begin
            step(vecs[k].r, vecs[k].l, vecs[k].i, vecs[k].d);
            chk($sformatf("vec%0d", k), out, wrap, vecs[k].eo, vecs[k].ew);
        end

        // reset suppresses a pending wrap
        dstep("sup_load", 0, 1, 0, 16'hFFFF, 16'hFFFF, 0);
        dstep("sup_rst",  1, 0, 1, 16'h0000, 16'h0000, 0);

        // reset mid-count
        dstep("mid_load", 0, 1, 0, 16'h00F0, 16'h00F0, 0);
        dstep("mid_i1",   0, 0, 1, 16'h0000, 16'h00F1, 0);
        dstep("mid_i2",   0, 0, 1, 16'h0000, 16'h00F2, 0);
        dstep("mid_i3",   0, 0, 1, 16'h0000, 16'h00F3, 0);
        dstep("mid_rst",  1, 0, 1, 16'h0000, 16'h0000, 0);
        dstep("mid_i4",   0, 0, 1, 16'h0000, 16'h0001, 0);

        // random traffic; loads biased toward the wrap boundary
        for (int n = 0; n < 3000; n++) begin
            logic        r, l, i;
            logic [15:0] d;
            r = ($urandom_range(0, 39) == 0);
            l = ($urandom_range(0, 7) == 0);
            i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1)
                d = 16'hFFFF - 16'($urandom_range(0, 4));
            else
                d = 16'($urandom);
            step(r, l, i, d);
            chk($sformatf("rand%0d", n), out, wrap, 16'(m_out), m_wrap);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
